// File: rtl/stim_pkg.sv
// stim_pkg: shared types and helpers for the stimulus vector generator.
// Mode/state encodings plus LFSR tap and sequence-length tables.
package stim_pkg;

   typedef enum logic [1:0] {
      MODE_BIN  = 2'd0,
      MODE_GRAY = 2'd1,
      MODE_LFSR = 2'd2,
      MODE_WALK = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Maximal-length tap masks, bit 0 = LSB of the register.
   function automatic logic [15:0] lfsr_taps(input int width);
      logic [15:0] t;
      case (width)
         2:       t = 16'h0003;
         3:       t = 16'h0006;
         4:       t = 16'h000C;
         5:       t = 16'h0014;
         6:       t = 16'h0030;
         7:       t = 16'h0060;
         8:       t = 16'h00B8;
         9:       t = 16'h0110;
         10:      t = 16'h0240;
         11:      t = 16'h0500;
         12:      t = 16'h0829;
         13:      t = 16'h100D;
         14:      t = 16'h2015;
         15:      t = 16'h6000;
         16:      t = 16'hD008;
         default: t = 16'h0000;
      endcase
      return t;
   endfunction

   // Number of vectors in one pass of a sequence.
   function automatic logic [16:0] seq_len(input mode_e m,
                                           input int width);
      logic [16:0] n;
      case (m)
         MODE_BIN:  n = 17'd1 << width;
         MODE_GRAY: n = 17'd1 << width;
         MODE_LFSR: n = (17'd1 << width) - 17'd1;
         default:   n = 17'(width);
      endcase
      return n;
   endfunction

endpackage

// File: rtl/stim_hold_timer.sv
// stim_hold_timer: counts HOLD cycles per vector.
// expire pulses on the last cycle of each hold window.
module stim_hold_timer #(
   parameter int HOLD = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   logic [CW-1:0] hcnt;

   assign expire = en && (hcnt == LAST);

   // Hold counter: restarts on clr, wraps at the end of each hold window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
      end else if (clr) begin
         hcnt <= '0;
      end else if (en) begin
         if (expire) begin
            hcnt <= '0;
         end else begin
            hcnt <= hcnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stim_vector_gen.sv
// stim_vector_gen: restartable clocked test-vector source.
// Binary, Gray, LFSR or walking-one sequences, each vector held HOLD cycles.
module stim_vector_gen
   import stim_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int HOLD  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic             loop,
   output logic [WIDTH-1:0] vec,
   output logic             vec_valid,
   output logic             busy,
   output logic             done
);

   localparam int IW = WIDTH + 1;
   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   state_e          state;
   mode_e           mode_r;
   logic [WIDTH:0]  idx;
   logic [WIDTH:0]  idx_nx;
   logic [WIDTH:0]  last_idx;
   logic [WIDTH-1:0] vec_nx;
   logic [WIDTH-1:0] first_v;
   logic            at_last;
   logic            fb;
   logic            expire;

   stim_hold_timer #(
      .HOLD (HOLD)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state != ST_RUN),
      .en     (state == ST_RUN),
      .expire (expire)
   );

   assign last_idx = IW'(seq_len(mode_r, WIDTH) - 17'd1);
   assign at_last  = (idx == last_idx);

   // Next index/vector and the first vector of a freshly started sequence.
   always_comb begin
      idx_nx  = at_last ? '0 : idx + IW'(1);
      fb      = ^(vec & TAPS);
      vec_nx  = '0;
      first_v = '0;
      unique case (mode_e'(mode))
         MODE_LFSR, MODE_WALK: first_v = WIDTH'(1);
         default:              first_v = '0;
      endcase
      unique case (mode_r)
         MODE_BIN:  vec_nx = idx_nx[WIDTH-1:0];
         MODE_GRAY: vec_nx = idx_nx[WIDTH-1:0] ^ idx_nx[WIDTH:1];
         MODE_LFSR: vec_nx = at_last ? WIDTH'(1)
                                     : {vec[WIDTH-2:0], fb};
         MODE_WALK: vec_nx = WIDTH'(1) << idx_nx;
         default:   vec_nx = '0;
      endcase
   end

   // Sequencer FSM with registered outputs; stop dominates everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mode_r    <= MODE_BIN;
         idx       <= '0;
         vec       <= '0;
         vec_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (stop) begin
         state     <= ST_IDLE;
         idx       <= '0;
         vec       <= '0;
         vec_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_RUN;
                  mode_r    <= mode_e'(mode);
                  idx       <= '0;
                  vec       <= first_v;
                  vec_valid <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            ST_RUN: begin
               if (expire) begin
                  if (at_last && !loop) begin
                     state     <= ST_DONE;
                     vec_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx <= idx_nx;
                     vec <= vec_nx;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stim_vector_gen.sv
// tb_stim_vector_gen: scoreboard bench for stim_vector_gen.
// Two instances: HOLD=5 (u0) and HOLD=1 (u1), both WIDTH=3.
module tb_stim_vector_gen;

   localparam int HOLD = 5;

   typedef struct {
      bit         sel;
      logic [2:0] vec;
      logic       valid;
      logic       busy;
      logic       done;
      bit         gray;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       loop = 1'b0;

   logic [2:0] vec0, vec1;
   logic       val0, val1, busy0, busy1, done0, done1;

   int checks = 0;
   int failures = 0;
   exp_t q[$];

   logic [2:0] bin_t [8] = '{3'd0, 3'd1, 3'd2, 3'd3,
                             3'd4, 3'd5, 3'd6, 3'd7};
   logic [2:0] gray_t[8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};
   logic [2:0] lfsr_t[8] = '{3'b001, 3'b010, 3'b101, 3'b011,
                             3'b111, 3'b110, 3'b100, 3'b000};

   always #5 clk = ~clk;

   stim_vector_gen #(.WIDTH(3), .HOLD(HOLD)) u0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start0),
      .stop      (stop),
      .mode      (mode),
      .loop      (loop),
      .vec       (vec0),
      .vec_valid (val0),
      .busy      (busy0),
      .done      (done0)
   );

   stim_vector_gen #(.WIDTH(3), .HOLD(1)) u1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start1),
      .stop      (stop),
      .mode      (mode),
      .loop      (loop),
      .vec       (vec1),
      .vec_valid (val1),
      .busy      (busy1),
      .done      (done1)
   );

   task automatic push_st(input bit s, input logic [2:0] v,
                          input logic va, input logic b,
                          input logic d, input int n,
                          input string tag, input bit g);
      exp_t e;
      e.sel = s; e.vec = v; e.valid = va;
      e.busy = b; e.done = d; e.gray = g; e.tag = tag;
      for (int i = 0; i < n; i++) q.push_back(e);
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (q.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout left=%0d required=0", q.size());
         q.delete();
      end
   endtask

   task automatic seq0(input logic [1:0] m, input logic [2:0] tv[8],
                       input int n, input string tag, input bit g);
      @(negedge clk);
      mode = m; loop = 1'b0; start0 = 1'b1;
      for (int i = 0; i < n; i++)
         push_st(0, tv[i], 1, 1, 0, HOLD, tag, g);
      push_st(0, tv[n-1], 0, 0, 1, 3, {tag, "_done"}, 0);
      @(negedge clk);
      start0 = 1'b0;
      wait_drain(200);
   endtask

   task automatic chk_direct(input string tag, input logic [5:0] act,
                             input logic [5:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%b required=%b", tag, act, req);
      end
   endtask

   // Monitor: one queue entry per clock, sampled 1 time unit after posedge.
   initial begin : monitor
      exp_t e;
      logic [2:0] av, pv;
      logic avl, ab, ad;
      bit pg;
      pg = 0; pv = '0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
               av = vec1; avl = val1; ab = busy1; ad = done1;
            end else begin
               av = vec0; avl = val0; ab = busy0; ad = done0;
            end
            checks++;
            if ({av, avl, ab, ad} !== {e.vec, e.valid, e.busy, e.done}) begin
               failures++;
               $display("FAIL %s vec/valid/busy/done got=%b/%b/%b/%b required=%b/%b/%b/%b",
                        e.tag, av, avl, ab, ad,
                        e.vec, e.valid, e.busy, e.done);
            end
            if (e.gray && pg && (av != pv)) begin
               checks++;
               if ($countones(av ^ pv) != 1) begin
                  failures++;
                  $display("FAIL gray_step prev=%b got=%b required=one-bit change",
                           pv, av);
               end
            end
            pg = e.gray;
            pv = av;
         end else begin
            pg = 0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (2) @(negedge clk);
      chk_direct("reset_u0", {vec0, val0, busy0, done0}, 6'b0);
      chk_direct("reset_u1", {vec1, val1, busy1, done1}, 6'b0);
      rst_n = 1'b1;
      push_st(0, 3'd0, 0, 0, 0, 2, "idle_u0", 0);
      push_st(1, 3'd0, 0, 0, 0, 2, "idle_u1", 0);
      wait_drain(20);

      seq0(2'd0, bin_t, 8, "bin", 0);
      seq0(2'd1, gray_t, 8, "gray", 1);
      seq0(2'd2, lfsr_t, 7, "lfsr", 0);

      // Walking-one with loop on the HOLD=1 instance, then stop.
      @(negedge clk);
      mode = 2'd3; loop = 1'b1; start1 = 1'b1;
      for (int r = 0; r < 4; r++) begin
         push_st(1, 3'b001, 1, 1, 0, 1, "walk", 0);
         push_st(1, 3'b010, 1, 1, 0, 1, "walk", 0);
         push_st(1, 3'b100, 1, 1, 0, 1, "walk", 0);
      end
      @(negedge clk);
      start1 = 1'b0;
      repeat (11) @(negedge clk);
      stop = 1'b1;
      push_st(1, 3'd0, 0, 0, 0, 2, "walk_stop", 0);
      @(negedge clk);
      stop = 1'b0; loop = 1'b0;
      wait_drain(20);

      // Stop together with start while binary RUN shows 011.
      @(negedge clk);
      mode = 2'd0; start0 = 1'b1;
      push_st(0, 3'd0, 1, 1, 0, 5, "pre_stop", 0);
      push_st(0, 3'd1, 1, 1, 0, 5, "pre_stop", 0);
      push_st(0, 3'd2, 1, 1, 0, 5, "pre_stop", 0);
      push_st(0, 3'd3, 1, 1, 0, 2, "pre_stop", 0);
      @(negedge clk);
      start0 = 1'b0;
      repeat (16) @(negedge clk);
      stop = 1'b1; start0 = 1'b1;
      push_st(0, 3'd0, 0, 0, 0, 3, "stop_clr", 0);
      @(negedge clk);
      stop = 1'b0; start0 = 1'b0;
      wait_drain(20);

      @(negedge clk);
      start0 = 1'b1;
      push_st(0, 3'd0, 1, 1, 0, 5, "restart", 0);
      push_st(0, 3'd1, 1, 1, 0, 1, "restart", 0);
      @(negedge clk);
      start0 = 1'b0;
      repeat (5) @(negedge clk);
      stop = 1'b1;
      push_st(0, 3'd0, 0, 0, 0, 1, "restart_stop", 0);
      @(negedge clk);
      stop = 1'b0;
      wait_drain(20);

      // Asynchronous reset in the middle of a hold window.
      @(negedge clk);
      start0 = 1'b1;
      push_st(0, 3'd0, 1, 1, 0, 3, "pre_rst", 0);
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_direct("async_rst", {vec0, val0, busy0, done0}, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      push_st(0, 3'd0, 0, 0, 0, 6, "post_rst_idle", 0);
      wait_drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stim_vector_gen.md
# stim_vector_gen

Synthesisable, parametrised test-vector generator for the architecture-testing benches. It drives a WIDTH-bit input bus to a device under test, stepping through a selectable sequence: binary count, Gray count, maximal-length LFSR or walking-one. Each vector is held for a programmable number of clock cycles. The block replaces free-running `forever` increment loops with a clocked, restartable source that reports valid, busy and done, so benches and on-chip self-test share one stimulus engine.

## Interface
- `WIDTH`, 3: vector width; legal range 2..16.
- `HOLD`, 5: clock cycles each vector is held; legal range ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a sequence; sampled in IDLE or DONE.
- `stop` in 1: abort to IDLE from any state.
- `mode` in 2: 0 binary, 1 Gray, 2 LFSR, 3 walking-one; sampled only on accepted `start`.
- `loop` in 1: 1 means restart at the first vector instead of entering DONE; sampled at each sequence end.
- `vec` out WIDTH: current vector.
- `vec_valid` out 1: `vec` is a live sequence vector.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when the last vector's hold expires and `loop`=0.
  - DONE→RUN on `start`.
  - any state→IDLE on `stop`.
- Internal state: index counter `idx` of width WIDTH+1, and hold counter `hcnt` of width clog2(HOLD+1).
- Sequence lengths N: binary 2^WIDTH; Gray 2^WIDTH; LFSR 2^WIDTH−1; walking-one WIDTH.
- Vector per mode:
  - Binary: `vec` = `idx[WIDTH-1:0]`.
  - Gray: `vec` = `idx ^ (idx>>1)`, truncated to WIDTH.
  - LFSR: Fibonacci form, seed 1, shift left; feedback = XOR of the tap bits from the package table. All-zero is never produced.
  - Walking-one: `vec` = 1<<`idx`.
- Vector advance: when `hcnt` = HOLD−1, `hcnt`←0 and the next vector is loaded; otherwise `hcnt` increments.
- Wrap with `loop`=1: after vector N−1 the sequence continues at vector 0 with no gap cycle and no DONE.
- `mode` changes during RUN are ignored.
- Priority: `stop` over `start`. `start` in RUN is ignored.

## Timing
- Reset values: `vec`=0, `vec_valid`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- Start latency: `start` seen at edge k puts the first vector on `vec` with `vec_valid`=`busy`=1 after edge k (registered, 1 cycle).
- Hold: every vector is stable for exactly HOLD cycles. A full sequence occupies N·HOLD cycles.
- End of sequence (`loop`=0): the cycle after the last vector's hold, `done`=1, `busy`=0, `vec_valid`=0, and `vec` holds the last vector. `done` stays high until `start` or `stop`.
- `start` in DONE: behaves as from IDLE; `done` drops in the same edge that loads the first vector.
- `stop`: the next edge clears `vec`, `vec_valid`, `busy` and `done`, and sets state IDLE.
- `rst_n` low mid-run: outputs go to reset values immediately, without waiting for a clock edge.
- HOLD=1: the vector changes every cycle.

## Structure
- Package `stim_pkg` holds:
  - mode enum;
  - state enum;
  - function `lfsr_taps(width)`, returning the maximal-length tap mask for 2..16 (e.g. 3: bits 2,1; 4: bits 3,2);
  - function `seq_len(mode, width)`.
- Sub-module `stim_hold_timer` (HOLD parameter, `clr`/`en` inputs, `expire` output) is the natural split. The top-level block keeps the FSM and vector logic.

## Test plan
- WIDTH=3, HOLD=5, binary, `start` pulse:
  - `vec` walks 000..111, each for 5 cycles;
  - `done`=1 exactly 40 cycles after the first vector;
  - `vec` stays 111.
- Gray, WIDTH=3:
  - `vec` = 000,001,011,010,110,111,101,100;
  - consecutive vectors differ in exactly one bit.
- LFSR, WIDTH=3:
  - `vec` = 001,010,101,011,111,110,100, then DONE;
  - 000 never appears; 7 vectors, 35 cycles.
- Walking-one, `loop`=1, HOLD=1:
  - `vec` = 001,010,100,001,… continuously;
  - `done` never rises.
- `stop` asserted with `start` during binary RUN at `vec`=011:
  - next edge gives `vec`=0, `busy`=0, state IDLE;
  - a later `start` restarts at 000.
- `rst_n` pulsed low mid-hold in RUN:
  - all outputs go to 0 asynchronously;
  - after release, the block waits in IDLE with no output activity until `start`.
